instr_fetch: RTL

Instruction fetch unit for the d16 core: walks the program counter, issues word reads to the memory port, and assembles complete instructions for the decoder. One-word instructions are delivered alone. Two-word instructions (bit 15 set, trailing immediate word) are delivered together with their immediate. Sits between the memory arbiter and the decoder, and handles branch redirects from the execute stage.

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch.sv | 121 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the d16 instruction fetch unit: state encodings,
// word width, PC step and the two-word instruction test.
package instr_fetch_pkg;

   localparam int unsigned WORD_W     = 16;
   localparam int unsigned IF_PC_STEP = 2;

   localparam logic [1:0] FS_FETCH_OP  = 2'd0;
   localparam logic [1:0] FS_FETCH_IMM = 2'd1;
   localparam logic [1:0] FS_VALID     = 2'd2;
   localparam logic [1:0] FS_DRAIN     = 2'd3;

   // Same rule the decoder uses for next_word: bit 15 marks a trailing immediate.
   function automatic logic next_word(input logic [WORD_W-1:0] instr);
      return instr[WORD_W-1];
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: walks the PC, reads words from memory and hands complete
// one- or two-word instructions to the decoder; handles execute-stage redirects.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
   parameter int unsigned       PC_STEP  = IF_PC_STEP
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_data,
   input  logic              pc_load,
   input  logic [WORD_W-1:0] pc_load_value,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_instr,
   output logic [WORD_W-1:0] out_imm,
   output logic [WORD_W-1:0] out_pc
);

   logic [1:0]        state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] drain_addr_q, drain_addr_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] out_instr_q, out_instr_d;
   logic [WORD_W-1:0] out_imm_q, out_imm_d;
   logic [WORD_W-1:0] out_pc_q, out_pc_d;
   logic [WORD_W-1:0] pc_next;

   assign pc_next = pc_q + WORD_W'(PC_STEP);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      out_instr_d  = out_instr_q;
      out_imm_d    = out_imm_q;
      out_pc_d     = out_pc_q;

      case (state_q)
         FS_FETCH_OP: begin
            if (pc_load) begin
               pc_d         = pc_load_value;
               drain_addr_d = pc_q;
               state_d      = mem_ack ? FS_FETCH_OP : FS_DRAIN;
            end else if (mem_ack) begin
               out_instr_d = mem_data;
               out_pc_d    = pc_q;
               pc_d        = pc_next;
               if (next_word(mem_data)) begin
                  state_d = FS_FETCH_IMM;
               end else begin
                  out_imm_d = '0;
                  state_d   = FS_VALID;
               end
            end
         end
         FS_FETCH_IMM: begin
            if (pc_load) begin
               pc_d         = pc_load_value;
               drain_addr_d = pc_q;
               state_d      = mem_ack ? FS_FETCH_OP : FS_DRAIN;
            end else if (mem_ack) begin
               out_imm_d = mem_data;
               pc_d      = pc_next;
               state_d   = FS_VALID;
            end
         end
         FS_VALID: begin
            if (pc_load) begin
               pc_d    = pc_load_value;
               state_d = FS_FETCH_OP;
            end else if (out_ready) begin
               state_d = FS_FETCH_OP;
            end
         end
         default: begin
            // DRAIN: the abandoned read must still complete before the new fetch.
            if (pc_load) begin
               pc_d = pc_load_value;
            end
            if (mem_ack) begin
               state_d = FS_FETCH_OP;
            end
         end
      endcase

      out_valid_d = (state_d == FS_VALID);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FS_FETCH_OP;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         out_valid_q  <= 1'b0;
         out_instr_q  <= '0;
         out_imm_q    <= '0;
         out_pc_q     <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_imm_q    <= out_imm_d;
         out_pc_q     <= out_pc_d;
      end
   end

   assign mem_req   = !rst && (state_q != FS_VALID);
   assign mem_addr  = (state_q == FS_DRAIN) ? drain_addr_q : pc_q;
   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_imm   = out_imm_q;
   assign out_pc    = out_pc_q;

endmodule
